// File: rtl/pc_unit_pkg.sv
// Shared types and defaults for the fetch-stage program counter and its
// return-address stack.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    PC_NORMAL = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RETURN = 2'b11
  } pc_inc_e;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_RAS_DEPTH  = 4;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h20;

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Circular return-address stack: push writes at ptr then increments, pop
// decrements then reads. A push when full overwrites the oldest entry.
module ret_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            din,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         ovf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_m1;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              do_push, do_pop;

  assign ptr_m1  = ptr_q - PTR_W'(1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(RAS_DEPTH));
  assign do_push = en && push;
  assign do_pop  = en && pop && !empty;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (do_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full) ovf_d   = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (do_pop) begin
      ptr_d   = ptr_m1;
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the entry array carries no reset; count gates its validity, and
  // leaving it unreset lets it map onto plain storage.
  always_ff @(negedge clk) begin
    if (do_push) mem_q[ptr_q] <= din;
  end

  assign top   = mem_q[ptr_m1];
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Word-addressed fetch-stage program counter with stall, exception redirect
// with EPC capture, and a return-address stack serving the RETURN mode.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0]  EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
  parameter int unsigned        RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        exc_req,
  input  logic [1:0]                  pc_inc_type,
  input  logic                        alu_branch_result,
  input  logic                        push_ret,
  input  logic [ADDR_W-1:0]           abs_addr,
  input  logic [ADDR_W-1:0]           branch_addr,
  output logic [ADDR_W-1:0]           current_pc,
  output logic [ADDR_W-1:0]           epc,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_underflow,
  output logic                        ras_overflow
);

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, pc_plus1;
  logic              unf_q, unf_d;
  logic              ras_push, ras_pop, ras_en, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign ras_en   = !stall && !exc_req;

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on the paths a mode does not touch.
  always_comb begin
    pc_d     = pc_plus1;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    unf_d    = 1'b0;
    unique case (pc_inc_e'(pc_inc_type))
      PC_NORMAL: ;
      PC_BRANCH: if (alu_branch_result) pc_d = pc_plus1 + branch_addr;
      PC_JUMP: begin
        pc_d     = abs_addr;
        ras_push = push_ret;
      end
      PC_RETURN: begin
        if (!ras_empty) begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end else begin
          pc_d  = abs_addr;
          unf_d = 1'b1;
        end
      end
    endcase
  end

  // Exception beats stall; a stalled or redirected update never pulses underflow.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
      unf_q <= 1'b0;
    end else if (exc_req) begin
      epc_q <= pc_q;
      pc_q  <= EXC_VECTOR;
      unf_q <= 1'b0;
    end else if (stall) begin
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      unf_q <= unf_d;
    end
  end

  ret_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .en    (ras_en),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus1),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty),
    .full  (),
    .ovf   (ras_overflow)
  );

  assign current_pc    = pc_q;
  assign epc           = epc_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for mode, RAS, stall and
// exception behaviour, and an 8-bit instance for address wrap.
module tb_pc_unit;

  localparam logic [1:0] M_NORM = 2'b00, M_BR = 2'b01, M_JMP = 2'b10, M_RET = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, stall, exc_req, alu_br, push_ret;
  logic [1:0]  mode;
  logic [31:0] abs_addr, br_addr, pc, epc;
  logic [2:0]  cnt;
  logic        unf, ovf;

  pc_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req),
    .pc_inc_type(mode), .alu_branch_result(alu_br), .push_ret(push_ret),
    .abs_addr(abs_addr), .branch_addr(br_addr),
    .current_pc(pc), .epc(epc), .ras_count(cnt),
    .ras_underflow(unf), .ras_overflow(ovf)
  );

  // 8-bit instance
  logic       b_rst, b_stall, b_exc, b_alu_br, b_push;
  logic [1:0] b_mode;
  logic [7:0] b_abs, b_br, b_pc, b_epc;
  logic [2:0] b_cnt;
  logic       b_unf, b_ovf;

  pc_unit #(.ADDR_W(8), .RESET_PC(8'h00), .EXC_VECTOR(8'h20), .RAS_DEPTH(4)) u_dut8 (
    .clk(clk), .rst(b_rst), .stall(b_stall), .exc_req(b_exc),
    .pc_inc_type(b_mode), .alu_branch_result(b_alu_br), .push_ret(b_push),
    .abs_addr(b_abs), .branch_addr(b_br),
    .current_pc(b_pc), .epc(b_epc), .ras_count(b_cnt),
    .ras_underflow(b_unf), .ras_overflow(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one update on the 32-bit instance, then sample just after the edge.
  task automatic step(input logic [1:0] m, input logic br, input logic psh,
                      input logic [31:0] a, input logic [31:0] off,
                      input logic stl, input logic exc);
    mode = m; alu_br = br; push_ret = psh; abs_addr = a; br_addr = off;
    stall = stl; exc_req = exc;
    @(negedge clk);
    #1;
  endtask

  task automatic step8(input logic [1:0] m, input logic br, input logic [7:0] a,
                       input logic [7:0] off);
    b_mode = m; b_alu_br = br; b_abs = a; b_br = off;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; exc_req = 1'b0; alu_br = 1'b0; push_ret = 1'b0;
    mode = M_NORM; abs_addr = '0; br_addr = '0;
    b_rst = 1'b1; b_stall = 1'b0; b_exc = 1'b0; b_alu_br = 1'b0; b_push = 1'b0;
    b_mode = M_NORM; b_abs = '0; b_br = '0;

    #2;
    check("reset_pc", pc, 32'h0);
    check("reset_epc", epc, 32'h0);
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_flags", {30'd0, unf, ovf}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    // NORMAL sequence and branches
    step(M_NORM, 0, 0, 0, 0, 0, 0); check("norm1", pc, 32'd1);
    step(M_NORM, 0, 0, 0, 0, 0, 0); check("norm2", pc, 32'd2);
    step(M_NORM, 0, 0, 0, 0, 0, 0); check("norm3", pc, 32'd3);
    step(M_BR, 1, 0, 0, 32'hFFFF_FFFE, 0, 0); check("br_taken", pc, 32'd2);
    step(M_BR, 0, 0, 0, 32'hFFFF_FFFE, 0, 0); check("br_not_taken", pc, 32'd3);

    // Call / return
    step(M_NORM, 0, 0, 0, 0, 0, 0);
    step(M_NORM, 0, 0, 0, 0, 0, 0); check("pc5", pc, 32'd5);
    step(M_JMP, 0, 1, 32'h40, 0, 0, 0); check("call_pc", pc, 32'h40);
    check("call_cnt", 32'(cnt), 32'd1);
    step(M_RET, 0, 0, 32'h77, 0, 0, 0); check("ret_pc", pc, 32'd6);
    check("ret_cnt", 32'(cnt), 32'd0);

    // Overflow: pushes of return addresses 1..5 into a 4-deep stack
    step(M_JMP, 0, 0, 32'h0, 0, 0, 0); check("jmp0", pc, 32'd0);
    for (int i = 1; i <= 4; i++) step(M_JMP, 0, 1, 32'(i), 0, 0, 0);
    check("full_cnt", 32'(cnt), 32'd4);
    check("full_no_ovf", 32'(ovf), 32'd0);
    step(M_JMP, 0, 1, 32'd5, 0, 0, 0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_cnt", 32'(cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(M_RET, 0, 0, 32'h77, 0, 0, 0);
      check($sformatf("pop%0d_pc", i), pc, 32'(5 - i));
      check($sformatf("pop%0d_cnt", i), 32'(cnt), 32'(3 - i));
    end
    step(M_RET, 0, 0, 32'h99, 0, 0, 0);
    check("unf_pc", pc, 32'h99);
    check("unf_pulse", 32'(unf), 32'd1);
    check("ovf_sticky", 32'(ovf), 32'd1);
    step(M_NORM, 0, 0, 0, 0, 0, 0);
    check("unf_clear", 32'(unf), 32'd0);
    check("after_unf_pc", pc, 32'h9A);

    // Stall and exception
    step(M_JMP, 0, 1, 32'h55, 0, 1, 0);
    check("stall_pc", pc, 32'h9A);
    check("stall_cnt", 32'(cnt), 32'd0);
    step(M_RET, 0, 0, 32'h66, 0, 1, 0);
    check("stall_ret_pc", pc, 32'h9A);
    check("stall_no_unf", 32'(unf), 32'd0);
    step(M_JMP, 0, 0, 32'h12, 0, 0, 0); check("pc12", pc, 32'h12);
    step(M_JMP, 0, 1, 32'h55, 0, 1, 1);
    check("exc_pc", pc, 32'h20);
    check("exc_epc", epc, 32'h12);
    check("exc_cnt", 32'(cnt), 32'd0);

    // Asynchronous reset mid-run with non-trivial state
    step(M_JMP, 0, 1, 32'h30, 0, 0, 0);
    check("prerst_cnt", 32'(cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_cnt", 32'(cnt), 32'd0);
    check("arst_flags", {30'd0, unf, ovf}, 32'd0);
    #1 rst = 1'b0;
    step(M_NORM, 0, 0, 0, 0, 0, 0); check("post_rst_pc", pc, 32'd1);

    // 8-bit wrap
    b_rst = 1'b0;
    step8(M_JMP, 0, 8'hFF, 8'h00); check("w8_jmp", 32'(b_pc), 32'hFF);
    step8(M_NORM, 0, 8'h00, 8'h00); check("w8_norm_wrap", 32'(b_pc), 32'h00);
    step8(M_JMP, 0, 8'h01, 8'h00); check("w8_jmp1", 32'(b_pc), 32'h01);
    step8(M_BR, 1, 8'h00, 8'hFD); check("w8_br_wrap", 32'(b_pc), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
